line_stack_reader: RTL and testbench
====================================

Name: line_stack_reader

Overview:
- Drains one line of 4-bit gray pixels from the line stack (LIFO) and packs them into 16-bit words for the IT8951 host-bus pixel writer.
- Read side of the stack: issues pops, absorbs the stack's 1-cycle read latency, and presents packed words on a valid/ready stream.
- Sits between the line stack and the IT8951 write-burst sequencer, one instance per line buffer.

Parameters:
- LINE_PIXELS, 800, pixels per line to drain; must be a multiple of 4.
- PIX_W, 4, pixel width in bits (4bpp gray).
- WORD_W, 16, output word width; PIXELS_PER_WORD = WORD_W/PIX_W = 4.
- CNT_W, 10, width of the pixel counters; 2^CNT_W > LINE_PIXELS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins draining a line; ignored while busy.
- stack_empty  in  1  stack empty flag.
- stack_ce  out  1  pop request to the stack; stack write-enable is tied low by the parent.
- stack_valid  in  1  popped pixel valid, one cycle after stack_ce.
- stack_do  in  PIX_W  popped pixel data.
- word_data  out  WORD_W  packed word.
- word_valid  out  1  word_data valid.
- word_ready  in  1  downstream accepts the word when word_valid && word_ready.
- busy  out  1  line in progress.
- done  out  1  1-cycle pulse after the last word is accepted.
- underrun  out  1  sticky; stack emptied before LINE_PIXELS pixels were popped. Cleared by start.
- word_cnt  out  CNT_W  words accepted in the current line.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Reset is asynchronous and may arrive mid-line. It aborts the line with no done pulse, and any partial word is discarded.

FSM:
- IDLE: on start, go to READ. Clear pop_cnt, nib_cnt, inflight, word_cnt and underrun.
- READ: on pop_cnt == LINE_PIXELS, or on stack_empty with no pop outstanding, go to FLUSH.
- FLUSH: wait for inflight == 0. If 0 < nib_cnt < 4, zero-pad the upper nibbles and move the word to the output register. When the output register is empty, go to DONE.
- DONE: assert done for 1 cycle, then go to IDLE.
- busy = (state != IDLE).

Pop issue:
- stack_ce is asserted only in READ, when all of the following hold:
  - pop_cnt < LINE_PIXELS;
  - !stack_empty;
  - credit > 0, where credit = 8 - 4*word_valid - nib_cnt - inflight.
- This guarantees every returned pixel has a slot, so stack_ce never needs to stall on word_ready.
- inflight is 0 or 1; it is set on a pop and cleared on the next cycle.

Packing:
- The first pixel of a word goes to bits [3:0]; the 4th pixel goes to [15:12]. This is IT8951 4bpp packing.
- A pop cycle whose following cycle has stack_valid low still counts as consumed: the pixel is packed as 0 and underrun is set.
- When nib_cnt reaches 4, the accumulator moves to the output register in the same cycle the register is empty or being accepted (word_valid && word_ready). Both paths are zero-bubble.
- Simultaneous events in one cycle are legal and resolved in this order: accept, move, pack.

Underrun:
- underrun is set when stack_empty is seen in READ with pop_cnt < LINE_PIXELS.
- The line still terminates normally, with a partial flush and done.

Output stream:
- word_valid stays high until accepted.
- word_data is stable while word_valid && !word_ready.
- word_cnt increments on each accept.

Arithmetic:
- pop_cnt and word_cnt are unsigned CNT_W bits and never wrap; LINE_PIXELS bounds both.

Optional Feature:
- Macro: LINE_STACK_READER_INVERT_EN.
- Defined: each pixel is inverted (~stack_do) before packing; zero-pad nibbles are packed as 4'hF (white).
- Undefined: pixels are packed as-is and pad nibbles are 4'h0.

Decomposition:
- Shared package it8951_pkg holds:
  - PIX_W and WORD_W constants;
  - the LINE_PIXELS default (800);
  - the reader FSM state typedef (IDLE/READ/FLUSH/DONE);
  - the pad-nibble constant.
- One natural sub-module, nibble_packer, owns the accumulator, nib_cnt, the output register and the valid/ready handshake. The top owns the FSM, pop issue and counters.

Test Plan:
- Stack preloaded with 800 pixels, pops returning 0,1,2,3,..., word_ready=1 -> 200 words; first word 16'h3210; done pulse 1 cycle after the 200th accept; word_cnt=200.
- Same load, word_ready toggled 1-of-3 cycles -> identical word sequence; word_data stable while stalled; no pixel lost or duplicated.
- Stack holding only 6 pixels (values 1..6) -> underrun=1; words 16'h4321 then 16'h0065; done asserted; busy drops.
- Reset pulsed mid-line after 37 pops -> all outputs 0 immediately; no done; next start runs a full clean line.
- start pulsed while busy -> ignored; pop_cnt and outputs unaffected.
- With LINE_STACK_READER_INVERT_EN and pixels 0,1,2,3 -> first word 16'hCDEF; underrun pad nibbles are F.

Source files
------------

// File: rtl/it8951_pkg.sv
// Shared IT8951 pixel-path constants and the line reader FSM state type.
// LINE_STACK_READER_INVERT_EN selects white (4'hF) padding instead of black.
package it8951_pkg;

  localparam int PIX_W           = 4;
  localparam int WORD_W          = 16;
  localparam int PIXELS_PER_WORD = WORD_W / PIX_W;
  localparam int LINE_PIXELS_DEF = 800;

`ifdef LINE_STACK_READER_INVERT_EN
  localparam logic [PIX_W-1:0] PAD_NIB = '1;
`else
  localparam logic [PIX_W-1:0] PAD_NIB = '0;
`endif

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_FLUSH,
    RD_DONE
  } rd_state_e;

endpackage

// File: rtl/line_stack_reader_nibble_packer.sv
// Packs pixels LSB-first into a word accumulator and hands full (or flushed,
// padded) words to a valid/ready output register.
module nibble_packer #(
  parameter int              PIX_W  = it8951_pkg::PIX_W,
  parameter int              WORD_W = it8951_pkg::WORD_W,
  parameter logic [PIX_W-1:0] PAD   = it8951_pkg::PAD_NIB,
  localparam int             NPW    = WORD_W / PIX_W,
  localparam int             NCW    = $clog2(NPW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              pack_en,
  input  logic [PIX_W-1:0]  pack_pix,
  input  logic              flush,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic [NCW-1:0]    nib_cnt,
  output logic              accept
);

  logic [WORD_W-1:0] acc_q, acc_d, out_q, out_d;
  logic [NCW-1:0]    nib_q, nib_d;
  logic              vld_q, vld_d;
  logic              move;

  // Event order within a cycle: accept, move, pack.
  always_comb begin
    accept = vld_q && word_ready;
    move   = (!vld_q || word_ready) &&
             ((nib_q == NCW'(NPW)) || (flush && (nib_q != '0)));
    acc_d  = acc_q;
    out_d  = out_q;
    nib_d  = nib_q;
    vld_d  = vld_q;
    if (accept) vld_d = 1'b0;
    if (move) begin
      out_d = acc_q;
      vld_d = 1'b1;
      acc_d = {NPW{PAD}};
      nib_d = '0;
    end
    if (pack_en) begin
      for (int i = 0; i < NPW; i++)
        if (nib_d == NCW'(i)) acc_d[i*PIX_W +: PIX_W] = pack_pix;
      nib_d = nib_d + NCW'(1);
    end
    if (clr) begin
      acc_d = {NPW{PAD}};
      nib_d = '0;
      vld_d = 1'b0;
    end
  end

  // Unwritten nibbles already hold PAD, so a flush needs no extra masking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= {NPW{PAD}};
      out_q <= '0;
      nib_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      nib_q <= nib_d;
      vld_q <= vld_d;
    end
  end

  assign word_data  = out_q;
  assign word_valid = vld_q;
  assign nib_cnt    = nib_q;

endmodule

// File: rtl/line_stack_reader.sv
// Drains one line of 4bpp pixels from the line stack and streams packed words.
// LINE_STACK_READER_INVERT_EN inverts each pixel before packing.
module line_stack_reader #(
  parameter int LINE_PIXELS = it8951_pkg::LINE_PIXELS_DEF,
  parameter int PIX_W       = it8951_pkg::PIX_W,
  parameter int WORD_W      = it8951_pkg::WORD_W,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stack_empty,
  output logic              stack_ce,
  input  logic              stack_valid,
  input  logic [PIX_W-1:0]  stack_do,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [CNT_W-1:0]  word_cnt
);
  import it8951_pkg::*;

  localparam int              NPW = WORD_W / PIX_W;
  localparam int              NCW = $clog2(NPW + 1);
  localparam int              UW  = NCW + 2;
  localparam logic [CNT_W-1:0] LP = CNT_W'(LINE_PIXELS);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             inflight_q, inflight_d;
  logic             underrun_q, underrun_d;

  logic [NCW-1:0]   nib_cnt;
  logic             accept, clr, flush;
  logic [PIX_W-1:0] pix_in, pack_pix;
  logic [UW-1:0]    used;
  logic             room;

`ifdef LINE_STACK_READER_INVERT_EN
  assign pix_in = ~stack_do;
`else
  assign pix_in = stack_do;
`endif

  // A pop is only issued when the returning pixel is guaranteed a slot.
  assign used = (word_valid ? UW'(NPW) : UW'(0)) + UW'(nib_cnt) + UW'(inflight_q);
  assign room = used < UW'(2 * NPW);

  always_comb begin
    state_d    = state_q;
    pop_cnt_d  = pop_cnt_q;
    word_cnt_d = word_cnt_q;
    underrun_d = underrun_q;
    inflight_d = 1'b0;
    stack_ce   = 1'b0;
    clr        = 1'b0;
    flush      = (state_q == RD_FLUSH) && !inflight_q;
    pack_pix   = stack_valid ? pix_in : '0;
    if (inflight_q && !stack_valid) underrun_d = 1'b1;
    if (accept) word_cnt_d = word_cnt_q + CNT_W'(1);
    case (state_q)
      RD_IDLE: if (start) begin
        state_d    = RD_READ;
        pop_cnt_d  = '0;
        word_cnt_d = '0;
        underrun_d = 1'b0;
        clr        = 1'b1;
      end
      RD_READ: begin
        stack_ce = (pop_cnt_q < LP) && !stack_empty && room;
        if (stack_ce) begin
          pop_cnt_d  = pop_cnt_q + CNT_W'(1);
          inflight_d = 1'b1;
        end
        if (stack_empty && (pop_cnt_q < LP)) underrun_d = 1'b1;
        if ((pop_cnt_q == LP) || (stack_empty && !inflight_q)) state_d = RD_FLUSH;
      end
      // Leave as the last word is accepted so done follows it by one cycle.
      RD_FLUSH: if (!inflight_q && (nib_cnt == '0) && (!word_valid || accept))
        state_d = RD_DONE;
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      pop_cnt_q  <= '0;
      word_cnt_q <= '0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop_cnt_q  <= pop_cnt_d;
      word_cnt_q <= word_cnt_d;
      inflight_q <= inflight_d;
      underrun_q <= underrun_d;
    end
  end

  nibble_packer #(
    .PIX_W  (PIX_W),
    .WORD_W (WORD_W),
    .PAD    (PAD_NIB)
  ) u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .pack_en    (inflight_q),
    .pack_pix   (pack_pix),
    .flush      (flush),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .nib_cnt    (nib_cnt),
    .accept     (accept)
  );

  assign busy     = (state_q != RD_IDLE);
  assign done     = (state_q == RD_DONE);
  assign underrun = underrun_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_line_stack_reader.sv
// Randomized bench: LIFO stack model feeding the reader, words scored against
// a line-level packing model built from the loaded stack contents.
module tb_line_stack_reader;

  localparam int LP = 800;

  logic        clk = 1'b0;
  logic        rst, start, stack_empty, stack_ce, stack_valid;
  logic [3:0]  stack_do;
  logic [15:0] word_data;
  logic        word_valid, word_ready, busy, done, underrun;
  logic [9:0]  word_cnt;

  always #5 clk = ~clk;

  line_stack_reader dut (
    .clk(clk), .rst(rst), .start(start), .stack_empty(stack_empty),
    .stack_ce(stack_ce), .stack_valid(stack_valid), .stack_do(stack_do),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .done(done), .underrun(underrun), .word_cnt(word_cnt)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

`ifdef LINE_STACK_READER_INVERT_EN
  localparam logic [3:0] PADV = 4'hF;
  function automatic logic [3:0] xf(input logic [3:0] p); return ~p; endfunction
`else
  localparam logic [3:0] PADV = 4'h0;
  function automatic logic [3:0] xf(input logic [3:0] p); return p; endfunction
`endif

  logic [3:0]  stk[$];
  logic [15:0] exp_w[$];
  int          acc_n, done_cnt, cyc_n, last_acc, pops, rdy_mode;
  bit          ce_l, prev_hold, start_nxt;
  logic [15:0] prev_data;

  // pmode: 0 = k%16, 1 = random, 2 = k+1
  task automatic load(input int avail, input int pmode);
    int n;
    stk.delete();
    exp_w.delete();
    for (int k = 0; k < avail; k++)
      stk.push_back(pmode == 0 ? 4'(k % 16) : pmode == 1 ? 4'($urandom) : 4'(k + 1));
    n = (avail < LP) ? avail : LP;
    for (int w = 0; w < (n + 3) / 4; w++) begin
      logic [15:0] x;
      for (int j = 0; j < 4; j++)
        x[j*4 +: 4] = (w*4 + j < n) ? xf(stk[w*4 + j]) : PADV;
      exp_w.push_back(x);
    end
  endtask

  // One clock: drive inputs just after the edge, observe at the falling edge.
  task automatic cyc();
    @(posedge clk); #1;
    if (ce_l && stk.size() > 0) begin
      stack_valid = 1'b1;
      stack_do    = stk.pop_front();
      pops++;
    end else begin
      stack_valid = 1'b0;
      stack_do    = 4'($urandom);
    end
    stack_empty = (stk.size() == 0);
    case (rdy_mode)
      0:       word_ready = 1'b1;
      1:       word_ready = (cyc_n % 3 == 0);
      default: word_ready = 1'($urandom_range(0, 1));
    endcase
    start     = start_nxt;
    start_nxt = 1'b0;
    @(negedge clk);
    cyc_n++;
    ce_l = stack_ce;
    if (prev_hold) begin
      chk("hold_vld", word_valid, 1);
      chk("hold_data", word_data, prev_data);
    end
    prev_hold = word_valid && !word_ready;
    prev_data = word_data;
    if (word_valid && word_ready) begin
      if (acc_n < exp_w.size()) chk($sformatf("word%0d", acc_n), word_data, exp_w[acc_n]);
      else chk("extra_word", acc_n + 1, exp_w.size());
      acc_n++;
      last_acc = cyc_n;
    end
    if (done) begin
      done_cnt++;
      if (acc_n > 0) chk("done_lat", cyc_n - last_acc, 1);
    end
  endtask

  task automatic begin_line(input int avail, input int pmode, input int rmode);
    load(avail, pmode);
    rdy_mode    = rmode;
    acc_n       = 0;
    done_cnt    = 0;
    pops        = 0;
    last_acc    = 0;
    prev_hold   = 1'b0;
    stack_empty = (stk.size() == 0);
    start_nxt   = 1'b1;
  endtask

  task automatic run_line(input int avail, input int pmode, input int rmode, input int stray_at);
    begin_line(avail, pmode, rmode);
    for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
      if (c == stray_at) start_nxt = 1'b1;
      cyc();
      if (c == stray_at + 2) chk("busy_stray", busy, 1);
    end
    chk("timeout", done_cnt, 1);
    cyc();
    cyc();
    chk("done_once", done_cnt, 1);
    chk("words", acc_n, exp_w.size());
    chk("word_cnt", word_cnt, exp_w.size());
    chk("underrun", underrun, avail < LP);
    chk("busy_end", busy, 0);
    chk("pops", pops, (avail < LP) ? avail : LP);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stack_empty = 1'b1; stack_valid = 1'b0;
    stack_do = '0; word_ready = 1'b0; cyc_n = 0; ce_l = 1'b0; start_nxt = 1'b0;
    rdy_mode = 0; prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vld", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_wcnt", word_cnt, 0);
    chk("rst_ce", stack_ce, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ce_l = stack_ce;

    run_line(LP, 0, 0, -1);   // ramp, always ready
    run_line(LP, 0, 1, 40);   // ramp, ready 1-of-3, stray start mid-line
    run_line(6, 2, 0, -1);    // short stack: underrun, padded tail word

    // reset mid-line after 37 pops
    begin_line(LP, 1, 2);
    for (int c = 0; c < 3000 && pops < 37; c++) cyc();
    chk("pre_rst_pops", pops, 37);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", word_valid, 0);
    chk("mid_rst_data", word_data, 0);
    chk("mid_rst_wcnt", word_cnt, 0);
    chk("mid_rst_ce", stack_ce, 0);
    chk("mid_rst_done", done, 0);
    chk("no_done", done_cnt, 0);
    stack_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ce_l = stack_ce;
    prev_hold = 1'b0;
    run_line(LP, 0, 0, -1);

    for (int t = 0; t < 4; t++) begin
      int av;
      av = ($urandom_range(0, 2) == 0) ? LP : $urandom_range(0, LP);
      run_line(av, 1, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
